parallel_adder: RTL and testbench

- Parameterised W-bit parallel-prefix adder computing {c_out, sum} = a + b + c_in.
- Datapath adder primitive for the ALU.
- Combinational Kogge-Stone carry network followed by one output register stage, giving single-cycle latency with a valid flag.
- Verification compares it against a behavioural n-bit model (plain a + b + c_in).

---
 rtl/parallel_adder_if.sv | 24 ++
 rtl/parallel_adder.sv | 81 ++++++++
 tb/tb_parallel_adder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/parallel_adder_if.sv
// Operand/result bundle for parallel_adder.
//   master : drives in_valid, a, b, c_in; observes sum, c_out, out_valid
//   slave  : the adder side, samples operands and drives the registered result
interface parallel_adder_if #(
   parameter int W = 64
);
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic [W-1:0] sum;
   logic         c_out;
   logic         out_valid;

   modport master (
      output in_valid, a, b, c_in,
      input  sum, c_out, out_valid
   );

   modport slave (
      input  in_valid, a, b, c_in,
      output sum, c_out, out_valid
   );
endinterface

// File: rtl/parallel_adder.sv
// W-bit Kogge-Stone adder with one output register stage.
// {c_out, sum} = a + b + c_in, registered one clock after in_valid is sampled.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears sum/c_out/out_valid
//   bus  : parallel_adder_if slave (in_valid, a, b, c_in -> sum, c_out, out_valid)
// W must be a power of two in 2..128 and match the interface width.
module parallel_adder #(
   parameter int W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   parallel_adder_if.slave      bus
);

   localparam int L = $clog2(W);

   if (W < 2 || W > 128 || (W & (W - 1)) != 0) begin : g_bad_w
      $error("parallel_adder: W=%0d must be a power of two in 2..128", W);
   end

   logic [W-1:0] p;
   logic [W-1:0] g0;
   logic [W:0]   carry;
   logic [W-1:0] sum_c;

   assign p  = bus.a ^ bus.b;
   // c_in folded into bit 0 so the prefix tree covers W positions in log2(W) levels.
   assign g0 = (bus.a & bus.b) | {{(W-1){1'b0}}, p[0] & bus.c_in};

   // Group propagate bits below D are never consumed at level k (only carries
   // down there are final), so each level keeps P only for bits >= D.
   genvar k, i;
   for (k = 0; k < L; k++) begin : g_lvl
      localparam int D = 1 << k;
      logic [W-1:0] g_in;
      logic [W-1:0] g_out;
      logic [W-1:D] p_in;

      if (k == 0) begin : g_src
         assign g_in = g0;
         assign p_in = p[W-1:D];
      end else begin : g_src
         assign g_in = g_lvl[k-1].g_out;
         assign p_in = g_lvl[k-1].g_pnext.p_out;
      end

      for (i = 0; i < W; i++) begin : g_g
         if (i >= D) begin : g_comb
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-D]);
         end else begin : g_pass
            assign g_out[i] = g_in[i];
         end
      end

      if (k < L - 1) begin : g_pnext
         logic [W-1:2*D] p_out;
         for (i = 2 * D; i < W; i++) begin : g_p
            assign p_out[i] = p_in[i] & p_in[i-D];
         end
      end
   end

   assign carry[0]   = bus.c_in;
   assign carry[W:1] = g_lvl[L-1].g_out;
   assign sum_c      = p ^ carry[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sum       <= '0;
         bus.c_out     <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.sum   <= sum_c;
            bus.c_out <= carry[W];
         end
      end
   end

endmodule

// File: tb/tb_parallel_adder.sv
// Self-checking bench for parallel_adder at W=64 and W=16.
module tb_parallel_adder;

   logic clk;
   logic rst;

   int checks;
   int failures;

   parallel_adder_if #(.W(64)) bus64 ();
   parallel_adder_if #(.W(16)) bus16 ();

   parallel_adder #(.W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
   parallel_adder #(.W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] model64(input logic [63:0] a, input logic [63:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {64'd0, c};
   endfunction

   function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {16'd0, c};
   endfunction

   task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c);
      logic [64:0] exp;
      @(negedge clk);
      bus64.in_valid = 1'b1;
      bus64.a        = a;
      bus64.b        = b;
      bus64.c_in     = c;
      exp = model64(a, b, c);
      @(posedge clk);
      #1;
      check(tag, {bus64.out_valid, bus64.c_out, bus64.sum}, {1'b1, exp});
      if ({bus64.out_valid, bus64.c_out, bus64.sum} !== {1'b1, exp})
         $display("  operands a=%h b=%h c_in=%b", a, b, c);
   endtask

   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] exp;
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.a        = a;
      bus16.b        = b;
      bus16.c_in     = c;
      exp = model16(a, b, c);
      @(posedge clk);
      #1;
      check(tag, {bus16.out_valid, bus16.c_out, bus16.sum}, {1'b1, exp});
      if ({bus16.out_valid, bus16.c_out, bus16.sum} !== {1'b1, exp})
         $display("  operands a=%h b=%h c_in=%b", a, b, c);
   endtask

   initial begin
      logic [64:0] held64;
      logic [64:0] exp64;
      checks   = 0;
      failures = 0;

      rst = 1'b1;
      bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.c_in = 1'b0;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0;
      #1;
      check("reset64", {bus64.out_valid, bus64.c_out, bus64.sum}, '0);
      check("reset16", {bus16.out_valid, bus16.c_out, bus16.sum}, '0);

      // Operands presented while in reset must not be captured.
      bus64.in_valid = 1'b1; bus64.a = 64'h1234; bus64.b = 64'h1; bus64.c_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("no_capture_in_reset", {bus64.out_valid, bus64.c_out, bus64.sum}, '0);
      @(negedge clk);
      rst = 1'b0;

      op64("zero_plus_cin", 64'h0, 64'h0, 1'b1);
      op64("zero_zero", 64'h0, 64'h0, 1'b0);
      op64("ones_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      op64("ones_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      op16("w16_ripple", 16'hFFFF, 16'h0001, 1'b1);
      op16("w16_ones_wrap", 16'hFFFF, 16'h0000, 1'b1);
      op16("w16_zero", 16'h0000, 16'h0000, 1'b0);

      // Hold: known result, then 5 idle cycles with changing/X operands.
      op64("hold_seed", 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 1'b0);
      held64 = model64(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 1'b0);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         bus64.in_valid = 1'b0;
         if (n % 2 == 0) begin
            bus64.a = 'x; bus64.b = 'x; bus64.c_in = 1'bx;
         end else begin
            bus64.a = {$urandom, $urandom}; bus64.b = {$urandom, $urandom}; bus64.c_in = 1'b1;
         end
         @(posedge clk);
         #1;
         check("hold", {bus64.out_valid, bus64.c_out, bus64.sum}, {1'b0, held64});
      end

      // Asynchronous reset mid-cycle while a fresh result is showing.
      op64("pre_reset", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", {bus64.out_valid, bus64.c_out, bus64.sum}, '0);
      @(posedge clk);
      #1;
      check("reset_held", {bus64.out_valid, bus64.c_out, bus64.sum}, '0);
      @(negedge clk);
      rst = 1'b0;
      bus64.in_valid = 1'b1; bus64.a = 64'h5; bus64.b = 64'h7; bus64.c_in = 1'b0;
      @(posedge clk);
      #1;
      exp64 = model64(64'h5, 64'h7, 1'b0);
      check("first_after_reset", {bus64.out_valid, bus64.c_out, bus64.sum}, {1'b1, exp64});

      // Back-to-back random streaming, one operation per clock.
      for (int n = 0; n < 10000; n++)
         op64("stream64", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      for (int n = 0; n < 500; n++)
         op16("stream16", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      @(negedge clk);
      bus64.in_valid = 1'b0;
      bus16.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("valid_drop64", {127'd0, bus64.out_valid}, 128'd0);
      check("valid_drop16", {127'd0, bus16.out_valid}, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
